// File: rtl/control_unit_if.sv
// Instruction-field and control-word bundle between instruction fetch and the
// MIPS control unit; the slave side is the decoder itself.
interface control_unit_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       MemtoReg;
    logic       MemWrite;
    logic       Branch;
    logic       ALUSrc;
    logic       RegDst;
    logic       RegWrite;
    logic [2:0] ALUControl;
    logic       Jump;

    modport master (
        output Opcode, Funct,
        input  MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, ALUControl, Jump
    );

    modport slave (
        input  Opcode, Funct,
        output MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, ALUControl, Jump
    );
endinterface

// File: rtl/control_unit.sv
// Registered main decoder plus ALU decoder for the single-cycle MIPS datapath:
// Opcode/Funct sampled on clk, full control word presented one cycle later.
module control_unit (
    input  logic          clk,
    input  logic          rst_n,
    control_unit_if.slave bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic       mem_write;
        logic       mem_to_reg;
        logic [2:0] alu_control;
        logic       jump;
    } ctrl_t;

    alu_op_e alu_op;
    ctrl_t   ctrl_d;
    ctrl_t   ctrl_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        ctrl_d = '0;
        alu_op = ALUOP_ADD;

        unique case (bus.Opcode)
            OP_RTYPE: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
                alu_op           = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d.branch = 1'b1;
                alu_op        = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
            end
            OP_J: begin
                ctrl_d.jump = 1'b1;
            end
            default: ;
        endcase

        case (alu_op)
            ALUOP_SUB: ctrl_d.alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (bus.Funct)
                    FN_ADD: ctrl_d.alu_control = ALU_ADD;
                    FN_SUB: ctrl_d.alu_control = ALU_SUB;
                    FN_AND: ctrl_d.alu_control = ALU_AND;
                    FN_OR:  ctrl_d.alu_control = ALU_OR;
                    FN_SLT: ctrl_d.alu_control = ALU_SLT;
                    default: begin
                        // Unsupported R-type behaves as a NOP: it must not write back.
                        ctrl_d.alu_control = ALU_ADD;
                        ctrl_d.reg_write   = 1'b0;
                    end
                endcase
            end
            default: ctrl_d.alu_control = ALU_ADD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctrl_q <= '0;
        else        ctrl_q <= ctrl_d;
    end

    assign bus.RegWrite   = ctrl_q.reg_write;
    assign bus.RegDst     = ctrl_q.reg_dst;
    assign bus.ALUSrc     = ctrl_q.alu_src;
    assign bus.Branch     = ctrl_q.branch;
    assign bus.MemWrite   = ctrl_q.mem_write;
    assign bus.MemtoReg   = ctrl_q.mem_to_reg;
    assign bus.ALUControl = ctrl_q.alu_control;
    assign bus.Jump       = ctrl_q.jump;

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit; words are compared as
// {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, ALUControl, Jump}.
module tb_control_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] opcode;
        logic [5:0] funct;
        logic [9:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] w(input logic rw, input logic rd, input logic as,
                                     input logic br, input logic mw, input logic mr,
                                     input logic [2:0] alu, input logic j);
        return {rw, rd, as, br, mw, mr, alu, j};
    endfunction

    function automatic logic [9:0] actual();
        return {bus.RegWrite, bus.RegDst, bus.ALUSrc, bus.Branch, bus.MemWrite,
                bus.MemtoReg, bus.ALUControl, bus.Jump};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic [9:0] exp,
                       input string name);
        vec_t v;
        v.opcode = op;
        v.funct  = fn;
        v.exp    = exp;
        v.name   = name;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic apply(input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        bus.Opcode = op;
        bus.Funct  = fn;
        @(posedge clk);
        #1;
    endtask

    logic [5:0] functs[5];
    logic [9:0] prev;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        functs[0] = 6'b100000;
        functs[1] = 6'b100010;
        functs[2] = 6'b100100;
        functs[3] = 6'b100101;
        functs[4] = 6'b101010;

        add(6'b000000, 6'b100000, w(1,1,0,0,0,0,3'b010,0), "rtype_add");
        add(6'b000000, 6'b100010, w(1,1,0,0,0,0,3'b110,0), "rtype_sub");
        add(6'b000000, 6'b100100, w(1,1,0,0,0,0,3'b000,0), "rtype_and");
        add(6'b000000, 6'b100101, w(1,1,0,0,0,0,3'b001,0), "rtype_or");
        add(6'b000000, 6'b101010, w(1,1,0,0,0,0,3'b111,0), "rtype_slt");
        for (int i = 0; i < 5; i++) add(6'b100011, functs[i], w(1,0,1,0,0,1,3'b010,0), "lw");
        for (int i = 0; i < 5; i++) add(6'b101011, functs[i], w(0,0,1,0,1,0,3'b010,0), "sw");
        for (int i = 0; i < 5; i++) add(6'b000100, functs[i], w(0,0,0,1,0,0,3'b110,0), "beq");
        for (int i = 0; i < 5; i++) add(6'b001000, functs[i], w(1,0,1,0,0,0,3'b010,0), "addi");
        add(6'b000010, 6'b000000, w(0,0,0,0,0,0,3'b010,1), "j_f0");
        add(6'b000010, 6'b101010, w(0,0,0,0,0,0,3'b010,1), "j_slt");
        add(6'b111111, 6'b100000, w(0,0,0,0,0,0,3'b010,0), "bad_opcode");
        add(6'b000000, 6'b000000, w(0,1,0,0,0,0,3'b010,0), "rtype_bad_funct");
        add(6'b000000, 6'b111111, w(0,1,0,0,0,0,3'b010,0), "rtype_bad_funct2");

        // Reset clears outputs with no clock edge, then one edge loads the word.
        rst_n      = 1'b0;
        bus.Opcode = 6'b000000;
        bus.Funct  = 6'b100000;
        #3;
        check("reset_async", actual(), 10'b0);
        @(negedge clk);
        check("reset_hold", actual(), 10'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", actual(), w(1,1,0,0,0,0,3'b010,0));

        // Back-to-back table sweep, also confirming the one-cycle latency.
        prev = actual();
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.Opcode = vecs[i].opcode;
            bus.Funct  = vecs[i].funct;
            #1;
            check({vecs[i].name, "_latency"}, actual(), prev);
            @(posedge clk);
            #1;
            check(vecs[i].name, actual(), vecs[i].exp);
            prev = vecs[i].exp;
        end

        // Mid-stream reset while lw is loaded, released with beq applied.
        apply(6'b100011, 6'b100000);
        check("mid_lw_loaded", actual(), w(1,0,1,0,0,1,3'b010,0));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_async", actual(), 10'b0);
        bus.Opcode = 6'b000100;
        bus.Funct  = 6'b100101;
        @(posedge clk);
        #1;
        check("mid_reset_held_over_edge", actual(), 10'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_release_beq", actual(), w(0,0,0,1,0,0,3'b110,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder plus ALU decoder for the single-cycle MIPS datapath.
- Maps the instruction Opcode and Funct fields to the datapath control strobes and the 3-bit ALU operation select.
- Outputs are registered on clk, so the control word is stable for a full cycle.
- Sits between instruction memory (Instr[31:26], Instr[5:0]) and the register file, ALU, data memory and PC-select muxes.

Parameters:
- None. Opcode, Funct and ALUControl widths are fixed by the MIPS ISA at 6, 6 and 3 bits.

Ports:
clk         input   1  system clock; all outputs update on its rising edge
rst_n       input   1  asynchronous, active-low reset
Opcode      input   6  instruction bits [31:26]
Funct       input   6  instruction bits [5:0]; used only for R-type
MemtoReg    output  1  1 = write-back data comes from data memory
MemWrite    output  1  1 = write data memory
Branch      output  1  1 = beq; PC source is taken when ALU Zero = 1
ALUSrc      output  1  1 = ALU operand B is the sign-extended immediate
RegDst      output  1  1 = destination register is rd; 0 = rt
RegWrite    output  1  1 = write the register file
ALUControl  output  3  ALU operation select
Jump        output  1  1 = PC source is the jump target

Behaviour:
- Reset: while rst_n = 0, all outputs are 0 immediately, independent of clk. This includes ALUControl = 3'b000.
- Reset release: the first rising clk edge with rst_n = 1 loads the decoded word.
- Latency: outputs reflect the Opcode/Funct sampled at the previous rising edge (1 cycle). There is no handshake.
- Combinational main decoder produces the strobes and a 2-bit internal ALUOp. Bit order below is RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, ALUOp, Jump:
  - R-type 000000: 1,1,0,0,0,0,10,0
  - lw 100011: 1,0,1,0,0,1,00,0
  - sw 101011: 0,0,1,0,1,0,00,0
  - beq 000100: 0,0,0,1,0,0,01,0
  - addi 001000: 1,0,1,0,0,0,00,0
  - j 000010: 0,0,0,0,0,0,00,1
  - Any other opcode: all strobes 0, ALUOp 00. No state change is possible.
- Don't-care fields are driven to 0, never X.
- ALU decoder:
  - ALUOp 00 -> ALUControl 010 (add); Funct is ignored.
  - ALUOp 01 -> ALUControl 110 (subtract); Funct is ignored.
  - ALUOp 10, by Funct:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 101010 -> 111 (slt)
  - ALUOp 10 with any other Funct: ALUControl 010, and RegWrite is forced to 0 (an unsupported R-type is a NOP).
- Funct has no effect on any output for non-R-type opcodes.
- Back-to-back instructions: each clock edge loads the new word in full. No partial update and no hold state.
- Reset asserted mid-stream: outputs clear asynchronously. They resume one edge after deassertion with the word for the then-current inputs.

Test Plan:
- Reset: rst_n = 0 with Opcode = 000000, Funct = 100000 -> all outputs 0 with no clk edge. Release, then one edge -> RegWrite = 1, RegDst = 1, ALUControl = 010.
- R-type sweep: Opcode = 000000, then Funct = 100000, 100010, 100100, 100101, 101010 on successive cycles -> ALUControl = 010, 110, 000, 001, 111, each one cycle later. RegWrite = 1, RegDst = 1, ALUSrc = 0, Branch = MemWrite = MemtoReg = Jump = 0.
- lw and sw, each across the same five Funct values:
  - lw 100011 -> RegWrite = 1, ALUSrc = 1, MemtoReg = 1, RegDst = 0, MemWrite = 0, ALUControl = 010 in every case.
  - sw 101011 -> MemWrite = 1, ALUSrc = 1, RegWrite = 0, ALUControl = 010 in every case.
- beq and addi across the five Funct values:
  - beq 000100 -> Branch = 1, ALUSrc = 0, RegWrite = 0, ALUControl = 110.
  - addi 001000 -> RegWrite = 1, ALUSrc = 1, RegDst = 0, MemtoReg = 0, ALUControl = 010.
- j and the unsupported cases:
  - j 000010 with any Funct -> Jump = 1, all other strobes 0, ALUControl = 010.
  - Opcode 111111 -> all strobes 0.
  - Opcode 000000 with Funct 000000 -> RegWrite = 0, ALUControl = 010.
- Mid-stream reset: assert rst_n = 0 asynchronously while lw is loaded -> outputs drop to 0 before the next edge. Release with beq applied -> Branch = 1 after one edge.
